wb_stage: RTL and testbench

//  Final (write-back) stage of the 5-stage LoongArch pipeline; consumes MEM_to_WB_bus from the MEM stage.

---
 rtl/wb_stage.sv | 145 ++++++++++++++
 tb/tb_wb_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: commits GPR/CSR/TLB effects, raises flushes,
// drives ID forwarding, the debug trace and the retired-instruction count.
module wb_stage #(
  parameter int BUS_W     = 198,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_to_WB_valid,
  input  logic [BUS_W-1:0]     MEM_to_WB_bus,
  output logic                 WB_allow_in,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [37:0]          WB_wr_bus,
  output logic                 csr_we,
  output logic [13:0]          csr_num,
  output logic [31:0]          csr_wmask,
  output logic [31:0]          csr_wvalue,
  output logic                 wb_ex,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [31:0]          wb_pc,
  output logic [31:0]          wb_vaddr,
  output logic                 ertn_flush,
  output logic                 refetch_flush,
  output logic [31:0]          refetch_pc,
  output logic                 tlbsrch_we,
  output logic                 tlbrd_en,
  output logic                 tlbwr_en,
  output logic                 tlbfill_en,
  output logic                 tlbsrch_hit,
  output logic [3:0]           tlbsrch_index,
  output logic [INSTRET_W-1:0] instret,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata
);

  typedef struct packed {
    logic        refetch;
    logic        tlbsrch;
    logic        tlbrd;
    logic        tlbwr;
    logic        tlbfill;
    logic        tlbhit;
    logic [3:0]  tlbidx;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic [5:0]  ex_type;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
  } mem_wb_t;

  mem_wb_t q;
  logic    wb_valid;
  logic    live;
  logic    ok;
  logic    flush;
  logic [5:0]  ecode;
  logic [31:0] vaddr;

  assign WB_allow_in = 1'b1;

  // resetn gates the held instruction so nothing commits in a reset cycle
  assign live  = wb_valid & resetn;
  assign ok    = live & ~|q.ex_type;
  assign flush = wb_ex | ertn_flush | refetch_flush;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_valid <= 1'b0;
      q        <= '0;
      instret  <= '0;
    end else begin
      wb_valid <= MEM_to_WB_valid & ~flush;
      if (MEM_to_WB_valid)
        q <= MEM_to_WB_bus;
      if (ok)
        instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    ecode = 6'h00;
    vaddr = 32'h0;
    priority case (1'b1)
      q.ex_type[5]: ecode = 6'h00;
      q.ex_type[4]: begin
        ecode = 6'h08;
        vaddr = q.pc;
      end
      q.ex_type[3]: ecode = 6'h0D;
      q.ex_type[1]: ecode = 6'h0C;
      q.ex_type[0]: ecode = 6'h0B;
      q.ex_type[2]: begin
        ecode = 6'h09;
        vaddr = q.result;
      end
      default: ;
    endcase
  end

  assign wb_ex       = live & |q.ex_type;
  assign wb_ecode    = wb_ex ? ecode : 6'h00;
  assign wb_esubcode = 9'h000;
  assign wb_pc       = live ? q.pc : 32'h0;
  assign wb_vaddr    = wb_ex ? vaddr : 32'h0;

  assign rf_we    = ok & q.gr_we & (q.dest != 5'd0);
  assign rf_waddr = live ? q.dest : 5'd0;
  assign rf_wdata = live ? q.result : 32'h0;

  // conservative: ID stalls on a faulting writer too
  assign WB_wr_bus = {live & q.gr_we, rf_waddr, rf_wdata};

  assign csr_we     = ok & q.csr_we;
  assign csr_num    = live ? q.csr_num : 14'h0;
  assign csr_wmask  = live ? q.csr_wmask : 32'h0;
  assign csr_wvalue = live ? q.csr_wvalue : 32'h0;

  assign ertn_flush    = ok & q.ertn;
  assign refetch_flush = ok & q.refetch;
  assign refetch_pc    = refetch_flush ? q.pc + 32'd4 : 32'h0;

  assign tlbsrch_we    = ok & q.tlbsrch;
  assign tlbrd_en      = ok & q.tlbrd;
  assign tlbwr_en      = ok & q.tlbwr;
  assign tlbfill_en    = ok & q.tlbfill;
  assign tlbsrch_hit   = tlbsrch_we & q.tlbhit;
  assign tlbsrch_index = tlbsrch_we ? q.tlbidx : 4'h0;

  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: commit gating, exception priority,
// flushes, TLB commands, instret and reset behaviour.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         MEM_to_WB_valid = 1'b0;
  logic [197:0] MEM_to_WB_bus = '0;
  logic         WB_allow_in;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [37:0]  WB_wr_bus;
  logic         csr_we;
  logic [13:0]  csr_num;
  logic [31:0]  csr_wmask;
  logic [31:0]  csr_wvalue;
  logic         wb_ex;
  logic [5:0]   wb_ecode;
  logic [8:0]   wb_esubcode;
  logic [31:0]  wb_pc;
  logic [31:0]  wb_vaddr;
  logic         ertn_flush;
  logic         refetch_flush;
  logic [31:0]  refetch_pc;
  logic         tlbsrch_we;
  logic         tlbrd_en;
  logic         tlbwr_en;
  logic         tlbfill_en;
  logic         tlbsrch_hit;
  logic [3:0]   tlbsrch_index;
  logic [63:0]  instret;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage dut (
    .clk(clk),
    .resetn(resetn),
    .MEM_to_WB_valid(MEM_to_WB_valid),
    .MEM_to_WB_bus(MEM_to_WB_bus),
    .WB_allow_in(WB_allow_in),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .WB_wr_bus(WB_wr_bus),
    .csr_we(csr_we),
    .csr_num(csr_num),
    .csr_wmask(csr_wmask),
    .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex),
    .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc),
    .wb_vaddr(wb_vaddr),
    .ertn_flush(ertn_flush),
    .refetch_flush(refetch_flush),
    .refetch_pc(refetch_pc),
    .tlbsrch_we(tlbsrch_we),
    .tlbrd_en(tlbrd_en),
    .tlbwr_en(tlbwr_en),
    .tlbfill_en(tlbfill_en),
    .tlbsrch_hit(tlbsrch_hit),
    .tlbsrch_index(tlbsrch_index),
    .instret(instret),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        refetch;
    logic        tlbsrch;
    logic        tlbrd;
    logic        tlbwr;
    logic        tlbfill;
    logic        tlbhit;
    logic [3:0]  tlbidx;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic [5:0]  ex_type;
    logic [31:0] result;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
  } bus_t;

  int n_checks = 0;
  int n_fail = 0;
  logic [63:0] exp_ir = 64'd0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents b for one cycle; returns at the negedge where WB holds it.
  task automatic issue(input bus_t b);
    @(negedge clk);
    MEM_to_WB_valid = 1'b1;
    MEM_to_WB_bus = b;
    @(negedge clk);
    MEM_to_WB_valid = 1'b0;
  endtask

  function automatic logic any_out();
    return |{rf_we, rf_waddr, rf_wdata, WB_wr_bus, csr_we, csr_num,
             csr_wmask, csr_wvalue, wb_ex, wb_ecode, wb_esubcode,
             wb_pc, wb_vaddr, ertn_flush, refetch_flush, refetch_pc,
             tlbsrch_we, tlbrd_en, tlbwr_en, tlbfill_en, tlbsrch_hit,
             tlbsrch_index, instret, debug_wb_pc, debug_wb_rf_we,
             debug_wb_rf_wnum, debug_wb_rf_wdata};
  endfunction

  bus_t b;
  logic [5:0]  ex_tab [7] = '{6'b000001, 6'b000010, 6'b001000,
                               6'b010000, 6'b110001, 6'b000110,
                               6'b000100};
  logic [5:0]  ec_tab [7] = '{6'h0B, 6'h0C, 6'h0D, 6'h08,
                               6'h00, 6'h0C, 6'h09};
  logic [31:0] va_tab [7] = '{32'h0, 32'h0, 32'h0, 32'h1c000040,
                               32'h0, 32'h0, 32'h20000001};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_zero", 64'(any_out()), 64'd0);
    check("allow_in", 64'(WB_allow_in), 64'd1);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_zero", 64'(any_out()), 64'd0);

    b = '0; b.gr_we = 1'b1; b.dest = 5'd5;
    b.result = 32'h1234; b.pc = 32'h1c000000;
    issue(b);
    check("add_rf_we", 64'(rf_we), 64'd1);
    check("add_waddr", 64'(rf_waddr), 64'd5);
    check("add_wdata", 64'(rf_wdata), 64'h1234);
    check("add_fwd", 64'(WB_wr_bus), {26'd0, 1'b1, 5'd5, 32'h1234});
    check("add_trace_we", 64'(debug_wb_rf_we), 64'hf);
    check("add_trace_pc", 64'(debug_wb_pc), 64'h1c000000);
    check("add_ir_before", instret, exp_ir);
    exp_ir++;
    @(negedge clk);
    check("add_ir_after", instret, exp_ir);
    check("add_we_gone", 64'(rf_we), 64'd0);

    b = '0; b.ex_type = 6'b000100; b.result = 32'h1003;
    b.gr_we = 1'b1; b.dest = 5'd3; b.pc = 32'h1c000010;
    issue(b);
    MEM_to_WB_valid = 1'b1;
    b = '0; b.gr_we = 1'b1; b.dest = 5'd9; b.result = 32'h99;
    MEM_to_WB_bus = b;
    check("ale_ex", 64'(wb_ex), 64'd1);
    check("ale_ecode", 64'(wb_ecode), 64'h09);
    check("ale_vaddr", 64'(wb_vaddr), 64'h1003);
    check("ale_era", 64'(wb_pc), 64'h1c000010);
    check("ale_rf_we", 64'(rf_we), 64'd0);
    check("ale_fwd_write", 64'(WB_wr_bus[37]), 64'd1);
    @(negedge clk);
    MEM_to_WB_valid = 1'b0;
    check("flush_drop_we", 64'(rf_we), 64'd0);
    check("flush_drop_fwd", 64'(WB_wr_bus[37]), 64'd0);
    check("flush_ir", instret, exp_ir);

    for (int i = 0; i < 7; i++) begin
      b = '0; b.ex_type = ex_tab[i]; b.pc = 32'h1c000040;
      b.result = 32'h20000001; b.gr_we = 1'b1; b.dest = 5'd4;
      issue(b);
      check($sformatf("ecode_%0d", i), 64'(wb_ecode), 64'(ec_tab[i]));
      check($sformatf("vaddr_%0d", i), 64'(wb_vaddr), 64'(va_tab[i]));
      check($sformatf("esub_%0d", i), 64'(wb_esubcode), 64'd0);
    end
    @(negedge clk);
    check("ex_no_ir", instret, exp_ir);

    b = '0; b.ertn = 1'b1; b.csr_we = 1'b1; b.csr_num = 14'h6;
    b.csr_wmask = 32'hffffffff; b.csr_wvalue = 32'habcd;
    issue(b);
    check("ertn_flush", 64'(ertn_flush), 64'd1);
    check("ertn_no_ex", 64'(wb_ex), 64'd0);
    check("csr_we", 64'(csr_we), 64'd1);
    check("csr_num", 64'(csr_num), 64'h6);
    check("csr_wmask", 64'(csr_wmask), 64'hffffffff);
    check("csr_wvalue", 64'(csr_wvalue), 64'habcd);
    exp_ir++;
    @(negedge clk);
    check("csr_we_once", 64'(csr_we), 64'd0);
    check("ertn_ir", instret, exp_ir);

    b = '0; b.tlbwr = 1'b1; b.refetch = 1'b1; b.pc = 32'h1c000100;
    issue(b);
    check("tlbwr_en", 64'(tlbwr_en), 64'd1);
    check("refetch_flush", 64'(refetch_flush), 64'd1);
    check("refetch_pc", 64'(refetch_pc), 64'h1c000104);
    check("refetch_no_ex", 64'(wb_ex), 64'd0);
    exp_ir++;

    b = '0; b.tlbsrch = 1'b1; b.tlbhit = 1'b1; b.tlbidx = 4'ha;
    b.gr_we = 1'b1; b.dest = 5'd0; b.result = 32'h55;
    issue(b);
    check("srch_we", 64'(tlbsrch_we), 64'd1);
    check("srch_hit", 64'(tlbsrch_hit), 64'd1);
    check("srch_idx", 64'(tlbsrch_index), 64'ha);
    check("r0_no_write", 64'(rf_we), 64'd0);
    exp_ir++;

    @(negedge clk);
    MEM_to_WB_valid = 1'b1;
    b = '0; b.gr_we = 1'b1; b.dest = 5'd1; b.result = 32'h11;
    MEM_to_WB_bus = b;
    @(negedge clk);
    b = '0; b.gr_we = 1'b1; b.dest = 5'd2; b.result = 32'h22;
    MEM_to_WB_bus = b;
    check("b2b_a_addr", 64'(rf_waddr), 64'd1);
    check("b2b_a_we", 64'(rf_we), 64'd1);
    @(negedge clk);
    MEM_to_WB_valid = 1'b0;
    check("b2b_b_addr", 64'(rf_waddr), 64'd2);
    check("b2b_b_data", 64'(rf_wdata), 64'h22);
    exp_ir += 2;
    @(negedge clk);
    check("b2b_ir", instret, exp_ir);

    b = '0; b.gr_we = 1'b1; b.dest = 5'd7; b.result = 32'h77;
    issue(b);
    resetn = 1'b0;
    #1;
    check("rst_no_we", 64'(rf_we), 64'd0);
    @(negedge clk);
    exp_ir = 64'd0;
    check("rst_ir", instret, exp_ir);
    check("rst_zero", 64'(any_out()), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_after_zero", 64'(any_out()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
